// File: rtl/calc_sequencer.sv
// calc_sequencer: multi-cycle signed arithmetic sequencer for the keypad calculator.
// Add/sub in one step; mul/div/mod share one iterative shift-add/subtract datapath.
module calc_sequencer #(
    parameter int          ITER     = 32,
    parameter int          MAX_POS  = 999999,
    parameter int          MIN_NEG  = -99999,
    parameter logic [31:0] ERR_CODE = 32'h00EE_0000
) (
    input  logic               clock_50m,
    input  logic               rst,
    input  logic               start,
    input  logic signed [31:0] operand1,
    input  logic signed [31:0] operand2,
    input  logic [2:0]         operator,
    output logic               busy,
    output logic               done,
    output logic signed [31:0] ans,
    output logic               err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_DIV = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_MOD = 3'd5;

    localparam logic signed [63:0] L_MAX = 64'(MAX_POS);
    localparam logic signed [63:0] L_MIN = 64'(MIN_NEG);
    localparam logic [5:0]         L_END = 6'(ITER - 1);

    logic [2:0]         r_state;
    logic signed [31:0] r_op1;
    logic signed [31:0] r_op2;
    logic [2:0]         r_opc;
    logic [31:0]        r_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [5:0]         r_cnt;
    logic               r_bad;
    logic               r_busy;
    logic               r_done;
    logic signed [31:0] r_ans;
    logic               r_err;

    logic [31:0]        w_mag1;
    logic [31:0]        w_mag2;
    logic               w_inv;
    logic               w_dz;
    logic               w_mul;
    logic               w_addsub;
    logic signed [32:0] w_sum33;
    logic [33:0]        w_x;
    logic [33:0]        w_y;
    logic [33:0]        w_alu;
    logic [31:0]        w_mag;
    logic               w_neg;
    logic signed [63:0] w_ext;
    logic signed [63:0] w_val;
    logic               w_ovf;
    logic               w_bad;

    assign w_mag1   = r_op1[31] ? -r_op1 : r_op1;
    assign w_mag2   = r_op2[31] ? -r_op2 : r_op2;
    assign w_inv    = (r_opc == 3'd0) || (r_opc > OP_MOD);
    assign w_dz     = ((r_opc == OP_DIV) || (r_opc == OP_MOD)) && (r_op2 == 32'sd0);
    assign w_mul    = (r_opc == OP_MUL);
    assign w_addsub = (r_opc == OP_ADD) || (r_opc == OP_SUB);
    assign w_sum33  = (r_opc == OP_ADD)
                    ? {r_op1[31], r_op1} + {r_op2[31], r_op2}
                    : {r_op1[31], r_op1} - {r_op2[31], r_op2};

    // Shared adder: mul adds multiplicand, div adds ~divisor+1 (carry-in)
    assign w_x   = w_mul ? {2'b00, r_hi} : {1'b0, r_hi, r_lo[31]};
    assign w_y   = w_mul ? (r_lo[0] ? {2'b00, r_b} : 34'd0) : ~{2'b00, r_b};
    assign w_alu = w_x + w_y + {33'd0, ~w_mul};

    always_comb begin
        w_mag = r_lo;
        w_neg = 1'b0;
        w_ovf = 1'b0;
        case (r_opc)
            OP_MUL: begin
                w_ovf = |r_hi;
                w_neg = r_op1[31] ^ r_op2[31];
            end
            OP_DIV: w_neg = r_op1[31] ^ r_op2[31];
            OP_MOD: begin
                w_mag = r_hi;
                w_neg = r_op1[31];
            end
            default: ;
        endcase
    end

    assign w_ext = {32'd0, w_mag};
    assign w_val = w_addsub ? $signed({r_hi, r_lo})
                 : (w_neg ? -w_ext : w_ext);
    assign w_bad = r_bad || w_ovf || (w_val > L_MAX) || (w_val < L_MIN);

    always_ff @(posedge clock_50m or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_op1   <= '0;
            r_op2   <= '0;
            r_opc   <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_bad   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ans   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op1   <= operand1;
                        r_op2   <= operand2;
                        r_opc   <= operator;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_hi    <= '0;
                    r_lo    <= w_mag1;
                    r_b     <= w_mag2;
                    r_cnt   <= '0;
                    r_bad   <= w_inv || w_dz;
                    r_state <= (w_inv || w_dz) ? S_CHECK : S_EXEC;
                end
                S_EXEC: begin
                    if (w_addsub) begin
                        {r_hi, r_lo} <= {{31{w_sum33[32]}}, w_sum33};
                        r_state      <= S_CHECK;
                    end else begin
                        if (w_mul) begin
                            r_hi <= w_alu[32:1];
                            r_lo <= {w_alu[0], r_lo[31:1]};
                        end else begin
                            r_hi <= w_alu[33] ? {r_hi[30:0], r_lo[31]} : w_alu[31:0];
                            r_lo <= {r_lo[30:0], ~w_alu[33]};
                        end
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == L_END) r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_ans   <= w_bad ? ERR_CODE : w_val[31:0];
                    r_err   <= w_bad;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign ans  = r_ans;
    assign err  = r_err;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed and random checks of calc_sequencer
// against an arithmetic reference model.
module tb_calc_sequencer;

    logic               clock_50m;
    logic               rst;
    logic               start;
    logic signed [31:0] operand1;
    logic signed [31:0] operand2;
    logic [2:0]         operator;
    logic               busy;
    logic               done;
    logic signed [31:0] ans;
    logic               err;

    int total;
    int bad;

    calc_sequencer dut (
        .clock_50m (clock_50m),
        .rst       (rst),
        .start     (start),
        .operand1  (operand1),
        .operand2  (operand2),
        .operator  (operator),
        .busy      (busy),
        .done      (done),
        .ans       (ans),
        .err       (err)
    );

    initial clock_50m = 1'b0;
    always #5 clock_50m = ~clock_50m;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic signed [31:0] a,
                                  input logic signed [31:0] b,
                                  input logic [2:0] op,
                                  output logic [31:0] o_ans,
                                  output logic o_err,
                                  output int o_lat);
        longint x;
        longint y;
        longint r;
        x = a;
        y = b;
        r = 0;
        o_err = 1'b0;
        o_lat = 34;
        if (op == 0 || op > 5 || ((op == 2 || op == 5) && y == 0)) begin
            o_err = 1'b1;
            o_lat = 2;
        end else begin
            case (op)
                3'd1: r = x * y;
                3'd2: r = x / y;
                3'd3: begin r = x + y; o_lat = 3; end
                3'd4: begin r = x - y; o_lat = 3; end
                default: r = x % y;
            endcase
            if (r > 999999 || r < -99999) o_err = 1'b1;
        end
        o_ans = o_err ? 32'h00EE_0000 : r[31:0];
    endfunction

    task automatic run_op(input logic signed [31:0] a,
                          input logic signed [31:0] b,
                          input logic [2:0] op);
        logic [31:0] e_ans;
        logic        e_err;
        int          e_lat;
        int          lat;
        model(a, b, op, e_ans, e_err, e_lat);
        @(negedge clock_50m);
        operand1 = a;
        operand2 = b;
        operator = op;
        start    = 1'b1;
        @(posedge clock_50m);
        #1;
        start    = 1'b0;
        operand1 = $urandom;
        operand2 = $urandom;
        operator = 3'($urandom);
        check("busy_rise", {31'd0, busy}, 32'd1);
        lat = 0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(posedge clock_50m);
            #1;
            if (done) lat = k;
        end
        check("latency", lat, e_lat);
        check("ans", ans, e_ans);
        check("err", {31'd0, err}, {31'd0, e_err});
        @(posedge clock_50m);
        #1;
        check("done_fall", {31'd0, done}, 32'd0);
        check("busy_fall", {31'd0, busy}, 32'd0);
    endtask

    function automatic logic signed [31:0] rnd_operand();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return $signed($urandom_range(0, 2000)) - 1000;
            2: return $signed($urandom_range(0, 2000000)) - 1000000;
            default: return 0;
        endcase
    endfunction

    initial begin
        int n_done;
        int lat;
        logic [31:0] got;
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        start    = 1'b0;
        operand1 = '0;
        operand2 = '0;
        operator = '0;
        repeat (3) @(posedge clock_50m);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ans", ans, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(negedge clock_50m);
        rst = 1'b1;

        for (int op = 1; op <= 5; op++) run_op(10, 101, 3'(op));
        for (int op = 1; op <= 5; op++) run_op(-10, -101, 3'(op));
        for (int op = 1; op <= 5; op++) run_op(100000, -500, 3'(op));
        run_op(1023, 0, 3'd2);
        run_op(1023, 0, 3'd5);
        run_op(1023, 0, 3'd0);
        run_op(1023, 0, 3'd7);
        run_op(1023, 0, 3'd3);
        run_op(999998, 1, 3'd3);
        run_op(999999, 1, 3'd3);
        run_op(-99998, 1, 3'd4);
        run_op(-99999, 1, 3'd4);
        run_op(32'sh8000_0000, -1, 3'd2);
        run_op(65536, 65536, 3'd1);
        run_op(-7, 2, 3'd5);
        run_op(0, -5, 3'd1);

        for (int i = 0; i < 40; i++)
            run_op(rnd_operand(), rnd_operand(), 3'($urandom_range(0, 7)));

        // second start while a multiply is in flight
        @(negedge clock_50m);
        operand1 = 10;
        operand2 = 101;
        operator = 3'd1;
        start    = 1'b1;
        @(posedge clock_50m);
        #1;
        start  = 1'b0;
        n_done = 0;
        lat    = 0;
        got    = '0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock_50m);
            #1;
            if (done) begin
                n_done++;
                if (lat == 0) lat = k;
                got = ans;
            end
            if (k == 4) begin
                operand1 = 3;
                operand2 = 3;
                operator = 3'd3;
                start    = 1'b1;
            end
            if (k == 5) start = 1'b0;
        end
        check("ign_count", n_done, 32'd1);
        check("ign_lat", lat, 32'd34);
        check("ign_ans", got, 32'd1010);

        // reset in the middle of a divide
        @(negedge clock_50m);
        operand1 = 1000;
        operand2 = 7;
        operator = 3'd2;
        start    = 1'b1;
        @(posedge clock_50m);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock_50m);
        #3;
        rst = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_ans", ans, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        @(negedge clock_50m);
        rst    = 1'b1;
        n_done = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clock_50m);
            #1;
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 32'd0);
        run_op(7, 8, 3'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
